// File: rtl/addr_stream_reader.sv
// Address-stream consumer: issues one memory read per accepted address and buffers the
// returning data in a credit-protected FIFO. Define ADDR_STREAM_READER_CNT_EN to add beat_cnt.
module addr_stream_reader #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              addr_valid,
    output logic              addr_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic              gen_done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [DATA_W-1:0] data,
`ifdef ADDR_STREAM_READER_CNT_EN
    output logic [ADDR_W-1:0] beat_cnt,
`endif
    output logic              done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = CW + 1;

    logic [DATA_W-1:0]   storage [DEPTH];
    logic [PW-1:0]       head_q, tail_q;
    logic [CW-1:0]       count_q, count_n;
    logic [READ_LAT-1:0] vld_q, vld_n;
    logic                seen_q, seen_n;
    logic                done_q, done_n;
    logic [OW-1:0]       inflight, inflight_n, occupied;
    logic                fire, push, pop;

    // Credits count both buffered words and reads still on their way back.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + OW'(vld_q[i]);
        end
        occupied   = OW'(count_q) + inflight;
        addr_ready = rst && !run && (occupied < OW'(DEPTH));
        fire       = addr_valid && addr_ready;
        push       = vld_q[READ_LAT-1];
        data_valid = (count_q != '0);
        pop        = data_valid && data_ready;
    end

    assign mem_en   = fire;
    assign mem_addr = addr;
    assign data     = storage[head_q];
    assign done     = done_q;

    // done looks at the post-edge state so it rises in the same cycle the block goes empty.
    always_comb begin
        vld_n[0] = fire;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_n[i] = vld_q[i-1];
        end
        inflight_n = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_n = inflight_n + OW'(vld_n[i]);
        end
        count_n = count_q + CW'(push) - CW'(pop);
        seen_n  = seen_q || gen_done;
        done_n  = done_q || (seen_n && (inflight_n == '0) && (count_n == '0));
    end

    always_ff @(posedge clk) begin
        if (!rst || run) begin
            vld_q   <= '0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            seen_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            vld_q   <= vld_n;
            count_q <= count_n;
            head_q  <= head_q + PW'(pop);
            tail_q  <= tail_q + PW'(push);
            seen_q  <= seen_n;
            done_q  <= done_n;
        end
    end

    // Storage holds no control state, so it needs no reset.
    always_ff @(posedge clk) begin
        if (rst && !run && push) begin
            storage[tail_q] <= mem_rdata;
        end
    end

`ifdef ADDR_STREAM_READER_CNT_EN
    logic [ADDR_W-1:0] beat_q;

    always_ff @(posedge clk) begin
        if (!rst || run) begin
            beat_q <= '0;
        end else if (pop) begin
            beat_q <= beat_q + ADDR_W'(1);
        end
    end

    assign beat_cnt = beat_q;
`endif

endmodule

// File: tb/tb_addr_stream_reader.sv
// Bench for addr_stream_reader: dut0 uses the default parameters, dut1 uses READ_LAT=3, DEPTH=8.
// A per-DUT scoreboard queue holds expected words; monitors pop and compare on every output beat.
module tb_addr_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0]       run_v        = '0;
    logic [1:0]       addr_valid_v = '0;
    logic [1:0]       gen_done_v   = '0;
    logic [1:0]       data_ready_v = '0;
    logic [1:0][9:0]  addr_v       = '0;
    logic [1:0]       addr_ready_v, mem_en_v, data_valid_v, done_v;
    logic [1:0][9:0]  mem_addr_v;
    logic [1:0][31:0] mem_rdata_v, data_v;
`ifdef ADDR_STREAM_READER_CNT_EN
    logic [1:0][9:0]  beat_cnt_v;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    int fire_cyc[$];
    int pop0_cyc[$];
    int pop1_cyc[$];
    int done0_cyc[$];
    logic done_prev0 = 1'b0;

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addr_stream_reader #(.ADDR_W(10), .DATA_W(32), .READ_LAT(1), .DEPTH(4)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .run        (run_v[0]),
        .addr_valid (addr_valid_v[0]),
        .addr_ready (addr_ready_v[0]),
        .addr       (addr_v[0]),
        .gen_done   (gen_done_v[0]),
        .mem_en     (mem_en_v[0]),
        .mem_addr   (mem_addr_v[0]),
        .mem_rdata  (mem_rdata_v[0]),
        .data_valid (data_valid_v[0]),
        .data_ready (data_ready_v[0]),
        .data       (data_v[0]),
`ifdef ADDR_STREAM_READER_CNT_EN
        .beat_cnt   (beat_cnt_v[0]),
`endif
        .done       (done_v[0])
    );

    addr_stream_reader #(.ADDR_W(10), .DATA_W(32), .READ_LAT(3), .DEPTH(8)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .run        (run_v[1]),
        .addr_valid (addr_valid_v[1]),
        .addr_ready (addr_ready_v[1]),
        .addr       (addr_v[1]),
        .gen_done   (gen_done_v[1]),
        .mem_en     (mem_en_v[1]),
        .mem_addr   (mem_addr_v[1]),
        .mem_rdata  (mem_rdata_v[1]),
        .data_valid (data_valid_v[1]),
        .data_ready (data_ready_v[1]),
        .data       (data_v[1]),
`ifdef ADDR_STREAM_READER_CNT_EN
        .beat_cnt   (beat_cnt_v[1]),
`endif
        .done       (done_v[1])
    );

    // Memory models: mem[a] = a + 100, returned READ_LAT cycles after the request.
    logic [9:0] m0_a, m1_a1, m1_a2, m1_a3;
    always @(posedge clk) begin
        m0_a  <= mem_addr_v[0];
        m1_a1 <= mem_addr_v[1];
        m1_a2 <= m1_a1;
        m1_a3 <= m1_a2;
    end
    assign mem_rdata_v[0] = 32'(m0_a) + 32'd100;
    assign mem_rdata_v[1] = 32'(m1_a3) + 32'd100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? exp0_q.size() : exp1_q.size();
    endfunction

    task automatic push_exp(input int d, input logic [31:0] v);
        if (d == 0) exp0_q.push_back(v);
        else        exp1_q.push_back(v);
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (rst && !run_v[0] && data_valid_v[0] && data_ready_v[0]) begin
            pop0_cyc.push_back(cyc);
            if (exp0_q.size() == 0) check("dut0_unexpected_beat", 64'(data_v[0]), 64'd0);
            else                    check("dut0_data", 64'(data_v[0]), 64'(exp0_q.pop_front()));
        end
        if (done_v[0] && !done_prev0) done0_cyc.push_back(cyc);
        done_prev0 <= done_v[0];
    end

    always @(negedge clk) begin
        if (rst && !run_v[1] && data_valid_v[1] && data_ready_v[1]) begin
            pop1_cyc.push_back(cyc);
            if (exp1_q.size() == 0) check("dut1_unexpected_beat", 64'(data_v[1]), 64'd0);
            else                    check("dut1_data", 64'(data_v[1]), 64'(exp1_q.pop_front()));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int d, input logic [9:0] base, input int n, input int budget,
                         input bit gd_last, output int acc);
        acc = 0;
        addr_valid_v[d] = 1'b1;
        addr_v[d]       = base;
        gen_done_v[d]   = gd_last && (n == 1);
        for (int c = 0; c < budget && acc < n; c++) begin
            @(negedge clk);
            if (addr_ready_v[d]) begin
                check("mem_en", 64'(mem_en_v[d]), 64'd1);
                check("mem_addr", 64'(mem_addr_v[d]), 64'(base + 10'(acc)));
                push_exp(d, 32'(base + 10'(acc)) + 32'd100);
                fire_cyc.push_back(cyc);
                acc++;
            end
            tick();
            addr_v[d]     = base + 10'(acc);
            gen_done_v[d] = gd_last && (acc == n - 1);
        end
        addr_valid_v[d] = 1'b0;
        gen_done_v[d]   = 1'b0;
    endtask

    task automatic pulse_run(input int d);
        run_v[d] = 1'b1;
        if (d == 0) exp0_q.delete();
        else        exp1_q.delete();
        @(negedge clk);
        check("run_addr_ready", 64'(addr_ready_v[d]), 64'd0);
        tick();
        run_v[d]      = 1'b0;
        gen_done_v[d] = 1'b0;
        @(negedge clk);
        check("run_data_valid", 64'(data_valid_v[d]), 64'd0);
        check("run_done", 64'(done_v[d]), 64'd0);
        tick();
    endtask

    task automatic wait_drain(input int d, input int budget);
        int n = 0;
        while (qsize(d) != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_remaining", 64'(qsize(d)), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;

        // reset state
        repeat (2) tick();
        @(negedge clk);
        check("rst_addr_ready0", 64'(addr_ready_v[0]), 64'd0);
        check("rst_addr_ready1", 64'(addr_ready_v[1]), 64'd0);
        check("rst_mem_en0", 64'(mem_en_v[0]), 64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_data_valid0", 64'(data_valid_v[0]), 64'd0);
        check("post_rst_done0", 64'(done_v[0]), 64'd0);
        check("post_rst_addr_ready0", 64'(addr_ready_v[0]), 64'd1);
        check("post_rst_data_valid1", 64'(data_valid_v[1]), 64'd0);
        tick();

        // streaming, defaults
        fire_cyc.delete(); pop0_cyc.delete(); done0_cyc.delete();
        data_ready_v[0] = 1'b1;
        offer(0, 10'd0, 8, 20, 1'b0, acc);
        check("stream_accepted", 64'(acc), 64'd8);
        gen_done_v[0] = 1'b1;
        tick();
        gen_done_v[0] = 1'b0;
        wait_drain(0, 30);
        repeat (2) tick();
        check("stream_pops", 64'(pop0_cyc.size()), 64'd8);
        check("stream_done_rises", 64'(done0_cyc.size()), 64'd1);
        if (fire_cyc.size() == 8 && pop0_cyc.size() == 8 && done0_cyc.size() == 1) begin
            check("stream_fire_span", 64'(fire_cyc[7] - fire_cyc[0]), 64'd7);
            check("stream_first_latency", 64'(pop0_cyc[0] - fire_cyc[0]), 64'd2);
            check("stream_pop_span", 64'(pop0_cyc[7] - pop0_cyc[0]), 64'd7);
            check("stream_done_delay", 64'(done0_cyc[0] - pop0_cyc[7]), 64'd1);
        end
`ifdef ADDR_STREAM_READER_CNT_EN
        check("stream_beat_cnt", 64'(beat_cnt_v[0]), 64'd8);
`endif

        // backpressure
        data_ready_v[0] = 1'b0;
        pulse_run(0);
        offer(0, 10'd50, 6, 10, 1'b0, acc);
        check("bp_accepted", 64'(acc), 64'd4);
        @(negedge clk);
        check("bp_addr_ready_full", 64'(addr_ready_v[0]), 64'd0);
        tick();
        fire_cyc.delete(); pop0_cyc.delete();
        data_ready_v[0] = 1'b1;
        offer(0, 10'd54, 2, 20, 1'b0, acc);
        check("bp_accepted_rest", 64'(acc), 64'd2);
        wait_drain(0, 30);
        check("bp_pops", 64'(pop0_cyc.size()), 64'd6);
        if (fire_cyc.size() != 0 && pop0_cyc.size() != 0)
            check("bp_credit_return", 64'(fire_cyc[0] - pop0_cyc[0]), 64'd1);

        // READ_LAT=3, DEPTH=8 full throughput
        fire_cyc.delete(); pop1_cyc.delete();
        data_ready_v[1] = 1'b1;
        offer(1, 10'd100, 16, 40, 1'b0, acc);
        check("lat_accepted", 64'(acc), 64'd16);
        wait_drain(1, 40);
        check("lat_pops", 64'(pop1_cyc.size()), 64'd16);
        if (fire_cyc.size() == 16 && pop1_cyc.size() == 16) begin
            check("lat_fire_span", 64'(fire_cyc[15] - fire_cyc[0]), 64'd15);
            check("lat_first_latency", 64'(pop1_cyc[0] - fire_cyc[0]), 64'd4);
            check("lat_pop_span", 64'(pop1_cyc[15] - pop1_cyc[0]), 64'd15);
        end

        // flush with two words buffered and two reads in flight
        data_ready_v[1] = 1'b0;
        offer(1, 10'd200, 4, 8, 1'b0, acc);
        check("flush_accepted", 64'(acc), 64'd4);
        tick();
        @(negedge clk);
        check("flush_pre_valid", 64'(data_valid_v[1]), 64'd1);
        check("flush_pre_head", 64'(data_v[1]), 64'd300);
        tick();
        pulse_run(1);
        repeat (4) tick();
        @(negedge clk);
        check("flush_dropped", 64'(data_valid_v[1]), 64'd0);
        tick();
        pop1_cyc.delete();
        data_ready_v[1] = 1'b1;
        offer(1, 10'd300, 3, 10, 1'b0, acc);
        wait_drain(1, 30);
        check("flush_new_pops", 64'(pop1_cyc.size()), 64'd3);

        // reset with a full FIFO
        data_ready_v[0] = 1'b0;
        offer(0, 10'd500, 4, 8, 1'b0, acc);
        tick();
        @(negedge clk);
        check("mid_rst_pre_valid", 64'(data_valid_v[0]), 64'd1);
        check("mid_rst_pre_head", 64'(data_v[0]), 64'd600);
        tick();
        rst = 1'b0;
        exp0_q.delete();
        exp1_q.delete();
        @(negedge clk);
        check("mid_rst_addr_ready", 64'(addr_ready_v[0]), 64'd0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_data_valid", 64'(data_valid_v[0]), 64'd0);
        check("mid_rst_done", 64'(done_v[0]), 64'd0);
`ifdef ADDR_STREAM_READER_CNT_EN
        check("mid_rst_beat_cnt", 64'(beat_cnt_v[0]), 64'd0);
`endif
        tick();

        // gen_done in the same cycle as the final fire
        pop0_cyc.delete(); done0_cyc.delete();
        data_ready_v[0] = 1'b1;
        offer(0, 10'd20, 3, 10, 1'b1, acc);
        wait_drain(0, 20);
        repeat (2) tick();
        check("gd_last_done_rises", 64'(done0_cyc.size()), 64'd1);
        if (done0_cyc.size() == 1 && pop0_cyc.size() == 3)
            check("gd_last_done_delay", 64'(done0_cyc[0] - pop0_cyc[2]), 64'd1);

        // gen_done coinciding with run is ignored
        gen_done_v[0] = 1'b1;
        pulse_run(0);
        repeat (2) tick();
        @(negedge clk);
        check("gd_with_run_ignored", 64'(done_v[0]), 64'd0);
        tick();

        // gen_done with no addresses, then a beat accepted while done
        gen_done_v[0] = 1'b1;
        @(negedge clk);
        check("gd_empty_before", 64'(done_v[0]), 64'd0);
        tick();
        gen_done_v[0] = 1'b0;
        @(negedge clk);
        check("gd_empty_done", 64'(done_v[0]), 64'd1);
        tick();
        offer(0, 10'd30, 1, 5, 1'b0, acc);
        check("done_state_accept", 64'(acc), 64'd1);
        wait_drain(0, 10);
        tick();
        @(negedge clk);
        check("done_sticky", 64'(done_v[0]), 64'd1);
`ifdef ADDR_STREAM_READER_CNT_EN
        check("done_beat_cnt", 64'(beat_cnt_v[0]), 64'd1);
`endif
        tick();

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
